// File: rtl/sd_cmd_arbiter.sv
// Two-requester command arbiter in front of sd_cmd_master: grant, issue, settle, wait, complete.
// Define SD_CMD_ARB_RR_EN for round-robin arbitration; the default is fixed priority (req1 wins).
`ifndef CMD_TIMEOUT_W
`define CMD_TIMEOUT_W 24
`endif
`ifndef INT_CMD_SIZE
`define INT_CMD_SIZE 5
`endif

module sd_cmd_arbiter (
  input  logic                      sd_clk,
  input  logic                      rst,
  input  logic                      req0_i,
  input  logic [13:0]               cmd0_i,
  input  logic [31:0]               arg0_i,
  input  logic [`CMD_TIMEOUT_W-1:0] tmo0_i,
  input  logic                      req1_i,
  input  logic [13:0]               cmd1_i,
  input  logic [31:0]               arg1_i,
  input  logic [`CMD_TIMEOUT_W-1:0] tmo1_i,
  output logic                      ack0_o,
  output logic                      ack1_o,
  output logic                      done0_o,
  output logic                      done1_o,
  output logic [`INT_CMD_SIZE-1:0]  status_o,
  output logic                      busy_o,
  output logic                      start_o,
  output logic [13:0]               command_o,
  output logic [31:0]               argument_o,
  output logic [`CMD_TIMEOUT_W-1:0] timeout_o,
  input  logic [`INT_CMD_SIZE-1:0]  int_status_i,
  output logic                      int_status_rst_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic [13:0]               command_q, command_d;
  logic [31:0]               argument_q, argument_d;
  logic [`CMD_TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [`INT_CMD_SIZE-1:0]  status_q, status_d;
  logic                      pick1;

`ifdef SD_CMD_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On contention the requester that was not granted last wins.
  assign pick1 = req1_i & (~req0_i | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && (req0_i || req1_i)) last_grant_d = pick1;
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign pick1 = req1_i;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    command_d  = command_q;
    argument_d = argument_q;
    timeout_d  = timeout_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          grant_d    = pick1;
          command_d  = pick1 ? cmd1_i : cmd0_i;
          argument_d = pick1 ? arg1_i : arg0_i;
          timeout_d  = pick1 ? tmo1_i : tmo0_i;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      // int_status_i may still carry the previous command's completion here.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (int_status_i[0] || int_status_i[1]) begin
          status_d = int_status_i;
          state_d  = S_DONE;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      command_q  <= '0;
      argument_q <= '0;
      timeout_q  <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      command_q  <= command_d;
      argument_q <= argument_d;
      timeout_q  <= timeout_d;
      status_q   <= status_d;
    end
  end

  assign start_o          = (state_q == S_ISSUE);
  assign ack0_o           = (state_q == S_ISSUE) & ~grant_q;
  assign ack1_o           = (state_q == S_ISSUE) &  grant_q;
  assign done0_o          = (state_q == S_DONE)  & ~grant_q;
  assign done1_o          = (state_q == S_DONE)  &  grant_q;
  assign int_status_rst_o = (state_q == S_DONE);
  assign busy_o           = (state_q != S_IDLE);
  assign status_o         = status_q;
  assign command_o        = command_q;
  assign argument_o       = argument_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: cycle vector table plus sequences for stale status,
// reset mid-command and grant order (expectations depend on SD_CMD_ARB_RR_EN).
`ifndef CMD_TIMEOUT_W
`define CMD_TIMEOUT_W 24
`endif
`ifndef INT_CMD_SIZE
`define INT_CMD_SIZE 5
`endif

module tb_sd_cmd_arbiter;

  logic                      sd_clk = 1'b0;
  logic                      rst;
  logic                      req0_i, req1_i;
  logic [13:0]               cmd0_i, cmd1_i;
  logic [31:0]               arg0_i, arg1_i;
  logic [`CMD_TIMEOUT_W-1:0] tmo0_i, tmo1_i;
  logic                      ack0_o, ack1_o, done0_o, done1_o;
  logic [`INT_CMD_SIZE-1:0]  status_o;
  logic                      busy_o, start_o;
  logic [13:0]               command_o;
  logic [31:0]               argument_o;
  logic [`CMD_TIMEOUT_W-1:0] timeout_o;
  logic [`INT_CMD_SIZE-1:0]  int_status_i;
  logic                      int_status_rst_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sd_clk = ~sd_clk;

  sd_cmd_arbiter dut (
    .sd_clk(sd_clk), .rst(rst),
    .req0_i(req0_i), .cmd0_i(cmd0_i), .arg0_i(arg0_i), .tmo0_i(tmo0_i),
    .req1_i(req1_i), .cmd1_i(cmd1_i), .arg1_i(arg1_i), .tmo1_i(tmo1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .done0_o(done0_o), .done1_o(done1_o),
    .status_o(status_o), .busy_o(busy_o), .start_o(start_o),
    .command_o(command_o), .argument_o(argument_o), .timeout_o(timeout_o),
    .int_status_i(int_status_i), .int_status_rst_o(int_status_rst_o)
  );

  typedef struct {
    logic       r0;
    logic       r1;
    logic [4:0] st;
    logic       start;
    logic       a0;
    logic       a1;
    logic       d0;
    logic       d1;
    logic       busy;
    logic       irst;
    logic [4:0] status;
    logic [13:0] cmd;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Push a vector: inputs for this cycle, outputs expected after the next edge.
  task automatic add(input logic r0, input logic r1, input logic [4:0] st,
                     input logic start, input logic a0, input logic a1,
                     input logic d0, input logic d1, input logic busy, input logic irst,
                     input logic [4:0] status, input logic [13:0] cmd);
    vec_t v;
    v = '{r0, r1, st, start, a0, a1, d0, d1, busy, irst, status, cmd};
    vq.push_back(v);
  endtask

  logic exp_order [6];

  initial begin
    rst = 1'b1;
    req0_i = 1'b0; req1_i = 1'b0;
    cmd0_i = 14'h0501; arg0_i = 32'hdeadbeef; tmo0_i = `CMD_TIMEOUT_W'(100);
    cmd1_i = 14'h0C19; arg1_i = 32'h12345678; tmo1_i = `CMD_TIMEOUT_W'(7);
    int_status_i = '0;

`ifdef SD_CMD_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Single request, completion after a long wait.
    add(1, 0, 5'd0, 1, 1, 0, 0, 0, 1, 0, 5'd0, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 14'h0501);
    for (int i = 0; i < 8; i++)
      add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 14'h0501);
    add(0, 0, 5'd1, 0, 0, 0, 1, 0, 1, 1, 5'd1, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 14'h0501);
    // Timeout/error status, then a normal follow-up command.
    add(1, 0, 5'd0, 1, 1, 0, 0, 0, 1, 0, 5'd1, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd1, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd1, 14'h0501);
    add(0, 0, 5'd6, 0, 0, 0, 1, 0, 1, 1, 5'd6, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 14'h0501);
    add(1, 0, 5'd0, 1, 1, 0, 0, 0, 1, 0, 5'd6, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd6, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd6, 14'h0501);
    add(0, 0, 5'd1, 0, 0, 0, 1, 0, 1, 1, 5'd1, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 14'h0501);
    // Contention after three req0 grants: req1 wins in both builds, req0 follows.
    add(1, 1, 5'd0, 1, 0, 1, 0, 0, 1, 0, 5'd1, 14'h0C19);
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd1, 14'h0C19);
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd1, 14'h0C19);
    add(1, 0, 5'd2, 0, 0, 0, 0, 1, 1, 1, 5'd2, 14'h0C19);
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd2, 14'h0C19);
    add(1, 0, 5'd0, 1, 1, 0, 0, 0, 1, 0, 5'd2, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 14'h0501);
    add(0, 0, 5'd1, 0, 0, 0, 1, 0, 1, 1, 5'd1, 14'h0501);
    add(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 14'h0501);

    // Reset state.
    step();
    step();
    chk("rst_start", start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", {ack0_o, ack1_o}, 0);
    chk("rst_done", {done0_o, done1_o}, 0);
    chk("rst_irst", int_status_rst_o, 0);
    chk("rst_fields", {status_o, command_o, argument_o}, 0);
    chk("rst_tmo", timeout_o, 0);
    rst = 1'b0;
    step();
    chk("idle_noreq_busy", busy_o, 0);

    for (int i = 0; i < vq.size(); i++) begin
      req0_i = vq[i].r0;
      req1_i = vq[i].r1;
      int_status_i = vq[i].st;
      step();
      chk($sformatf("v%0d_start", i), start_o, vq[i].start);
      chk($sformatf("v%0d_ack", i), {ack0_o, ack1_o}, {vq[i].a0, vq[i].a1});
      chk($sformatf("v%0d_done", i), {done0_o, done1_o}, {vq[i].d0, vq[i].d1});
      chk($sformatf("v%0d_busy", i), busy_o, vq[i].busy);
      chk($sformatf("v%0d_irst", i), int_status_rst_o, vq[i].irst);
      chk($sformatf("v%0d_status", i), status_o, vq[i].status);
      chk($sformatf("v%0d_cmd", i), command_o, vq[i].cmd);
    end
    req0_i = 1'b0; req1_i = 1'b0; int_status_i = '0;

    // Stale completion held through SETTLE; fields change after ack.
    int_status_i = 5'b00001;
    req0_i = 1'b1;
    step();
    chk("stale_start", start_o, 1);
    chk("stale_arg", argument_o, 32'hdeadbeef);
    chk("stale_tmo", timeout_o, 100);
    req0_i = 1'b0; cmd0_i = 14'h3FFF; arg0_i = 32'h0; tmo0_i = '0;
    step();
    chk("stale_settle_done", {done0_o, done1_o}, 0);
    step();
    chk("stale_wait_done", {done0_o, done1_o}, 0);
    step();
    chk("stale_done0", done0_o, 1);
    chk("stale_cmd_held", command_o, 14'h0501);
    chk("stale_arg_held", argument_o, 32'hdeadbeef);
    chk("stale_tmo_held", timeout_o, 100);
    int_status_i = '0;
    cmd0_i = 14'h0501; arg0_i = 32'hdeadbeef; tmo0_i = `CMD_TIMEOUT_W'(100);
    step();
    chk("stale_idle", busy_o, 0);

    // Reset asserted while waiting for completion.
    req0_i = 1'b1;
    step();
    req0_i = 1'b0;
    step();
    step();
    chk("rw_in_wait", busy_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_busy", busy_o, 0);
    chk("rw_done", {done0_o, done1_o}, 0);
    chk("rw_ctrl", {start_o, ack0_o, ack1_o, int_status_rst_o}, 0);
    chk("rw_fields", {status_o, command_o, argument_o}, 0);
    chk("rw_tmo", timeout_o, 0);
    int_status_i = 5'b00001;
    step();
    rst = 1'b0;
    step();
    chk("rw_after_done", {done0_o, done1_o}, 0);
    chk("rw_after_busy", busy_o, 0);
    int_status_i = '0;
    req1_i = 1'b1;
    step();
    chk("rw_req1_ack", {ack0_o, ack1_o}, 2'b01);
    chk("rw_req1_cmd", command_o, 14'h0C19);
    chk("rw_req1_arg", argument_o, 32'h12345678);
    req1_i = 1'b0;
    step();
    step();
    int_status_i = 5'b00001;
    step();
    chk("rw_req1_done", {done0_o, done1_o}, 2'b01);
    int_status_i = '0;
    step();

    // Grant order with both requesters held high from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_i = 1'b1; req1_i = 1'b1;
    for (int g = 0; g < 6; g++) begin
      int k;
      k = 0;
      step();
      while (!start_o && k < 8) begin
        step();
        k++;
      end
      chk($sformatf("order%0d_start", g), start_o, 1);
      chk($sformatf("order%0d_grant", g), {ack0_o, ack1_o}, {~exp_order[g], exp_order[g]});
      int_status_i = 5'b00001;
      k = 0;
      while (busy_o && k < 8) begin
        step();
        k++;
      end
      chk($sformatf("order%0d_idle", g), busy_o, 0);
      int_status_i = '0;
    end
    req0_i = 1'b0; req1_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 Port list, in order; each port SHALL have the given name, direction, width and meaning:
- sd_clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- req0_i  in  1  host requester command request, level.
- cmd0_i  in  14  host command word, sd_cmd_master command_i format.
- arg0_i  in  32  host argument.
- tmo0_i  in  `CMD_TIMEOUT_W  host timeout.
- req1_i, cmd1_i, arg1_i, tmo1_i  in  1/14/32/`CMD_TIMEOUT_W  auxiliary requester (auto CMD12/CMD13 engine), same meanings.
- ack0_o, ack1_o  out  1  one-cycle pulse: fields of that requester latched.
- done0_o, done1_o  out  1  one-cycle pulse: that requester's command completed.
- status_o  out  `INT_CMD_SIZE  captured completion status, valid with doneN_o and held until the next capture.
- busy_o  out  1  high in every state except IDLE.
- start_o  out  1  to sd_cmd_master start_i.
- command_o, argument_o, timeout_o  out  14/32/`CMD_TIMEOUT_W  to sd_cmd_master command_i/argument_i/timeout_i.
- int_status_i  in  `INT_CMD_SIZE  from sd_cmd_master int_status_o (bit0 CC, bit1 EI).
- int_status_rst_o  out  1  to sd_cmd_master int_status_rst_i.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high (sd_clk, rst).

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, SETTLE, WAIT and DONE.
REQ-004 IDLE: when any reqN_i is sampled high, the block SHALL latch the winner's cmd/arg/tmo into command_o/argument_o/timeout_o, record the grant and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-005 ISSUE: start_o=1 and ackN_o=1 for the granted requester for exactly one cycle, then go to SETTLE.
REQ-006 SETTLE: one cycle and int_status_i ignored, so stale status from the previous command is never sampled; then go to WAIT.
REQ-007 WAIT: on int_status_i[0]|int_status_i[1] the block SHALL capture int_status_i into status_o and go to DONE; otherwise it SHALL stay in WAIT indefinitely, relying on the sd_cmd_master timeout.
REQ-008 DONE: doneN_o=1 for the granted requester and int_status_rst_o=1 for one cycle, then go to IDLE.
REQ-009 Latency: a request sampled at edge k SHALL give start_o high in cycle k+1; the earliest doneN_o SHALL be 3 cycles after start_o.
REQ-010 command_o, argument_o and timeout_o SHALL be stable from ISSUE through DONE; reqN_i, cmd, arg and tmo changes after ack SHALL have no effect on the command in flight.
REQ-011 Simultaneous requests: the arbitration rule SHALL follow REQ-015/REQ-016; the loser SHALL be served on the next return to IDLE if still requesting.
REQ-012 A request asserted during ISSUE through DONE SHALL be held off; it SHALL be granted no earlier than the cycle after int_status_rst_o.
REQ-013 reqN_i still high in IDLE after doneN_o SHALL be treated as a new command; requesters SHALL drop req on ack.

Reset
REQ-014 On rst the FSM SHALL go to IDLE, and every output SHALL be 0: start_o, ackN_o, doneN_o, busy_o, int_status_rst_o, status_o, command_o, argument_o, timeout_o. Asserting rst mid-command SHALL abandon it with no doneN_o.

Configuration
REQ-015 Without SD_CMD_ARB_RR_EN, arbitration SHALL be fixed priority, with req1_i winning over req0_i.
REQ-016 With SD_CMD_ARB_RR_EN, arbitration SHALL be round-robin: on contention, the requester not granted last wins; last_grant SHALL reset to 1, so req0 wins the first contention; a single request is always granted.

Verification
REQ-017 Single request: req0 with cmd0=0x0501, arg0=0xdeadbeef, tmo0=100 -> start_o and ack0_o pulse in the next cycle; command_o=0x0501, argument_o=0xdeadbeef; int_status_i=5'b00001 after 10 cycles -> done0_o with status_o=5'b00001 and int_status_rst_o in the same cycle.
REQ-018 Timeout: int_status_i=5'b00110 during WAIT -> done0_o with status_o=5'b00110; the next req0 is issued normally.
REQ-019 Contention, macro off: req0 and req1 asserted in the same cycle -> req1 is served first, then req0 with start_o no earlier than 1 cycle after int_status_rst_o.
REQ-020 Contention, macro on: three consecutive simultaneous req0+req1 pairs -> grant order 0,1,0,1,0,1.
REQ-021 Stale status: int_status_i held at 5'b00001 from the prior command during SETTLE -> ignored, and no doneN_o until WAIT samples it.
REQ-022 Reset mid-WAIT: rst pulse -> all outputs 0, no doneN_o, busy_o=0; a subsequent req1 with cmd1=0x0C19 is issued.
